// File: rtl/bus_port_fifo_bank.sv
// Per-device FIFO bank for the bus arbiter: one FWFT transmit FIFO per channel
// (agent fills, arbiter drains) and one receive capture register per channel.
module bus_port_fifo_bank #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter int          ovf_mode  = 0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [drvrs-1:0]                     wr_en,
  input  logic [drvrs*pckg_sz-1:0]             wr_data,
  output logic [drvrs-1:0]                     full,
  output logic [drvrs*$clog2(depth+1)-1:0]     count,
  output logic [drvrs-1:0]                     pndng,
  output logic [drvrs*pckg_sz-1:0]             D_pop,
  input  logic [drvrs-1:0]                     pop,
  input  logic [drvrs-1:0]                     push,
  input  logic [drvrs*pckg_sz-1:0]             D_push,
  output logic [drvrs*pckg_sz-1:0]             rx_data,
  output logic [drvrs-1:0]                     rx_vld,
  output logic [drvrs-1:0]                     rx_bcst,
  input  logic [drvrs-1:0]                     rx_ack,
  output logic [drvrs-1:0]                     rx_ovr,
  output logic [drvrs-1:0]                     pop_err,
  output logic [drvrs*8-1:0]                   drop_cnt
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic OVW = (ovf_mode != 0);

  for (genvar g = 0; g < drvrs; g++) begin : g_ch
    logic [pckg_sz-1:0] mem_q [depth];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         drop_q, drop_d;
    logic               pop_err_q, pop_err_d;
    logic [pckg_sz-1:0] rx_data_q, rx_data_d;
    logic               rx_vld_q, rx_vld_d, rx_bcst_q, rx_bcst_d, rx_ovr_q, rx_ovr_d;
    logic               is_empty, is_full, do_pop, do_wr, adv, drop;
    logic [pckg_sz-1:0] wdat, pdat;

    assign wdat = wr_data[g*pckg_sz +: pckg_sz];
    assign pdat = D_push[g*pckg_sz +: pckg_sz];

    always_comb begin
      is_empty  = (cnt_q == '0);
      is_full   = (cnt_q == CW'(depth));
      do_pop    = pop[g] & ~is_empty;
      // In overwrite mode a full write without pop evicts the head so count holds.
      do_wr     = wr_en[g] & (~is_full | do_pop | OVW);
      adv       = do_pop | (wr_en[g] & is_full & OVW);
      drop      = wr_en[g] & is_full & ~do_pop;
      rd_ptr_d  = adv   ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d  = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
      cnt_d     = cnt_q;
      if (do_wr && !adv)      cnt_d = cnt_q + CW'(1);
      else if (adv && !do_wr) cnt_d = cnt_q - CW'(1);
      drop_d    = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      pop_err_d = pop_err_q | (pop[g] & is_empty);

      rx_data_d = rx_data_q;
      rx_vld_d  = rx_vld_q;
      rx_bcst_d = rx_bcst_q;
      rx_ovr_d  = rx_ovr_q;
      if (push[g]) begin
        rx_data_d = pdat;
        rx_vld_d  = 1'b1;
        rx_bcst_d = (pdat[pckg_sz-1 -: 8] == broadcast);
        rx_ovr_d  = rx_ovr_q | (rx_vld_q & ~rx_ack[g]);
      end else if (rx_ack[g] && rx_vld_q) begin
        rx_vld_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_ptr_q  <= '0;
        wr_ptr_q  <= '0;
        cnt_q     <= '0;
        drop_q    <= '0;
        pop_err_q <= 1'b0;
        rx_data_q <= '0;
        rx_vld_q  <= 1'b0;
        rx_bcst_q <= 1'b0;
        rx_ovr_q  <= 1'b0;
      end else begin
        rd_ptr_q  <= rd_ptr_d;
        wr_ptr_q  <= wr_ptr_d;
        cnt_q     <= cnt_d;
        drop_q    <= drop_d;
        pop_err_q <= pop_err_d;
        rx_data_q <= rx_data_d;
        rx_vld_q  <= rx_vld_d;
        rx_bcst_q <= rx_bcst_d;
        rx_ovr_q  <= rx_ovr_d;
      end
    end

    // Storage needs no reset: the head is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wdat;
    end

    assign full[g]                       = is_full;
    assign pndng[g]                      = ~is_empty;
    assign count[g*CW +: CW]             = cnt_q;
    assign D_pop[g*pckg_sz +: pckg_sz]   = is_empty ? '0 : mem_q[rd_ptr_q];
    assign rx_data[g*pckg_sz +: pckg_sz] = rx_data_q;
    assign rx_vld[g]                     = rx_vld_q;
    assign rx_bcst[g]                    = rx_bcst_q;
    assign rx_ovr[g]                     = rx_ovr_q;
    assign pop_err[g]                    = pop_err_q;
    assign drop_cnt[g*8 +: 8]            = drop_q;
  end

endmodule

// File: tb/tb_bus_port_fifo_bank.sv
// Bench for bus_port_fifo_bank: a drop-mode and an overwrite-mode instance share stimulus;
// popped heads are checked against per-instance expected queues by a negedge monitor.
module tb_bus_port_fifo_bank;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]   wr_en = '0, pop = '0, push = '0, rx_ack = '0, chk_pop = '0;
  logic [N*W-1:0] wr_data = '0, D_push = '0;

  logic [N-1:0]    full0, pndng0, rx_vld0, rx_bcst0, rx_ovr0, pop_err0;
  logic [N-1:0]    full1, pndng1, rx_vld1, rx_bcst1, rx_ovr1, pop_err1;
  logic [N*CW-1:0] count0, count1;
  logic [N*W-1:0]  D_pop0, D_pop1, rx_data0, rx_data1;
  logic [N*8-1:0]  drop0, drop1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_port_fifo_bank #(.drvrs(N), .pckg_sz(W), .depth(8), .ovf_mode(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full0),
    .count(count0), .pndng(pndng0), .D_pop(D_pop0), .pop(pop), .push(push),
    .D_push(D_push), .rx_data(rx_data0), .rx_vld(rx_vld0), .rx_bcst(rx_bcst0),
    .rx_ack(rx_ack), .rx_ovr(rx_ovr0), .pop_err(pop_err0), .drop_cnt(drop0));

  bus_port_fifo_bank #(.drvrs(N), .pckg_sz(W), .depth(8), .ovf_mode(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full1),
    .count(count1), .pndng(pndng1), .D_pop(D_pop1), .pop(pop), .push(push),
    .D_push(D_push), .rx_data(rx_data1), .rx_vld(rx_vld1), .rx_bcst(rx_bcst1),
    .rx_ack(rx_ack), .rx_ovr(rx_ovr1), .pop_err(pop_err1), .drop_cnt(drop1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop flagged as valid by the driver consumes one expected head per instance.
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (chk_pop[c]) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_underflow ch%0d: got pop with no expected entry", c);
        end else begin
          check($sformatf("d0_pop_data_ch%0d", c), 32'(D_pop0[c*W +: W]), 32'(exp_q0.pop_front()));
          check($sformatf("d1_pop_data_ch%0d", c), 32'(D_pop1[c*W +: W]), 32'(exp_q1.pop_front()));
          check($sformatf("d0_pndng_at_pop_ch%0d", c), 32'(pndng0[c]), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = '0; pop = '0; push = '0; rx_ack = '0; chk_pop = '0;
  endtask

  task automatic set_wr(input int ch, input logic [W-1:0] d);
    wr_en[ch] = 1'b1;
    wr_data[ch*W +: W] = d;
  endtask

  task automatic set_pop(input int ch, input logic [W-1:0] e0, input logic [W-1:0] e1);
    pop[ch] = 1'b1;
    chk_pop[ch] = 1'b1;
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  task automatic set_push(input int ch, input logic [W-1:0] d);
    push[ch] = 1'b1;
    D_push[ch*W +: W] = d;
  endtask

  initial begin
    #12 reset = 1'b0;
    step();
    // reset state
    check("rst_pndng", 32'(pndng0), 32'h0);
    check("rst_count", 32'(count0), 32'h0);
    check("rst_full", 32'(full0), 32'h0);
    check("rst_dpop", 32'(D_pop0), 32'h0);
    check("rst_rxvld", 32'(rx_vld0), 32'h0);
    check("rst_drop", 32'(drop1), 32'h0);

    // single write then pop
    set_wr(0, 16'hFF33); step();
    check("wr1_pndng0", 32'(pndng0[0]), 32'd1);
    check("wr1_dpop0", 32'(D_pop0[0 +: W]), 32'hFF33);
    check("wr1_count0", 32'(count0[0 +: CW]), 32'd1);
    set_pop(0, 16'hFF33, 16'hFF33); step();
    check("pop1_pndng0", 32'(pndng0[0]), 32'd0);
    check("pop1_count0", 32'(count0[0 +: CW]), 32'd0);

    // fill ch2 with 9 packets: drop mode keeps 0100..0107, overwrite keeps 0101..0108
    for (int k = 0; k < 9; k++) begin set_wr(2, 16'h0100 + 16'(k)); step(); end
    check("fill_full2_d0", 32'(full0[2]), 32'd1);
    check("fill_full2_d1", 32'(full1[2]), 32'd1);
    check("fill_drop2_d0", 32'(drop0[16 +: 8]), 32'd1);
    check("fill_drop2_d1", 32'(drop1[16 +: 8]), 32'd1);
    check("fill_count2_d1", 32'(count1[8 +: CW]), 32'd8);
    for (int k = 0; k < 8; k++) begin
      set_pop(2, 16'h0100 + 16'(k), 16'h0101 + 16'(k)); step();
    end
    check("drain_count2", 32'(count0[8 +: CW]), 32'd0);

    // drop counter saturation
    for (int k = 0; k < 308; k++) begin set_wr(2, 16'h0200 + 16'(k)); step(); end
    check("sat_drop2_d0", 32'(drop0[16 +: 8]), 32'd255);
    check("sat_drop2_d1", 32'(drop1[16 +: 8]), 32'd255);

    // full ch1: write + pop together keeps count at depth, no drop
    for (int k = 0; k < 8; k++) begin set_wr(1, 16'h1000 + 16'(k)); step(); end
    set_wr(1, 16'h1ABC); set_pop(1, 16'h1000, 16'h1000); step();
    check("wp_full_count1", 32'(count0[4 +: CW]), 32'd8);
    check("wp_full_drop1_d0", 32'(drop0[8 +: 8]), 32'd0);
    check("wp_full_drop1_d1", 32'(drop1[8 +: 8]), 32'd0);
    for (int k = 1; k < 8; k++) begin set_pop(1, 16'h1000 + 16'(k), 16'h1000 + 16'(k)); step(); end
    set_pop(1, 16'h1ABC, 16'h1ABC); step();

    // empty ch3: pop + write
    set_wr(3, 16'h3333); pop[3] = 1'b1; step();
    check("ep_pop_err", 32'(pop_err0), 32'h8);
    check("ep_count3", 32'(count0[12 +: CW]), 32'd1);
    set_pop(3, 16'h3333, 16'h3333); step();

    // rx path
    set_push(1, 16'hFF55); step();
    check("rx1_vld", 32'(rx_vld0[1]), 32'd1);
    check("rx1_bcst", 32'(rx_bcst0[1]), 32'd1);
    check("rx1_data", 32'(rx_data0[W +: W]), 32'hFF55);
    set_push(1, 16'h0277); step();
    check("rx2_data", 32'(rx_data0[W +: W]), 32'h0277);
    check("rx2_bcst", 32'(rx_bcst0[1]), 32'd0);
    check("rx2_ovr", 32'(rx_ovr0[1]), 32'd1);
    set_push(2, 16'h0011); step();
    set_push(2, 16'hFF22); rx_ack[2] = 1'b1; step();
    check("rx3_vld", 32'(rx_vld0[2]), 32'd1);
    check("rx3_ovr", 32'(rx_ovr0[2]), 32'd0);
    check("rx3_data", 32'(rx_data0[2*W +: W]), 32'hFF22);
    rx_ack[2] = 1'b1; step();
    check("rx4_vld_cleared", 32'(rx_vld0[2]), 32'd0);
    rx_ack[2] = 1'b1; step();
    check("rx5_ack_idle", 32'(rx_vld0[2] | rx_ovr0[2]), 32'd0);

    // reset mid-operation
    for (int k = 0; k < 5; k++) begin set_wr(0, 16'h0A00 + 16'(k)); step(); end
    set_push(0, 16'h5555); step();
    check("pre_rst_count0", 32'(count0[0 +: CW]), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("mr_pndng", 32'(pndng0), 32'h0);
    check("mr_count", 32'(count0), 32'h0);
    check("mr_dpop", 32'(D_pop0), 32'h0);
    check("mr_rx", 32'(rx_vld0 | rx_ovr0 | pop_err0), 32'h0);
    check("mr_rxdata", 32'(rx_data0), 32'h0);
    check("mr_drop", 32'(drop0), 32'h0);
    #1 reset = 1'b0;
    set_wr(0, 16'hABCD); step();
    check("post_rst_dpop0", 32'(D_pop0[0 +: W]), 32'hABCD);
    check("post_rst_count0", 32'(count0[0 +: CW]), 32'd1);
    set_pop(0, 16'hABCD, 16'hABCD); step();
    step();
    check("exp_q_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_port_fifo_bank.md
Name: bus_port_fifo_bank

Overview:
Synthesizable per-device FIFO bank emulating the `drvrs` device ports attached to the bus generator/arbiter (`bs_gntrt_n_rbtr`).
- TX side: each channel holds a `depth`-deep first-word-fall-through transmit FIFO, loaded by the agent and drained by the arbiter via `pndng`/`pop`/`D_pop`.
- RX side: each channel has a capture register written by the arbiter via `push`/`D_push`, with broadcast detection.
- Replaces the fixed single-entry device model with configurable depth, channel count and overflow policy, plus error and statistics outputs.

Parameters:
- drvrs, 4, number of device channels (1..16).
- pckg_sz, 16, packet width in bits (≥ 9); bits [pckg_sz-1:pckg_sz-8] carry the destination id.
- depth, 8, TX FIFO entries per channel; must be a power of two, 2..64.
- ovf_mode, 0, TX write when full: 0 = drop incoming packet, 1 = overwrite oldest packet.
- broadcast, 8'hFF, id value meaning broadcast.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  drvrs  agent write strobe per channel.
- wr_data  in  drvrs*pckg_sz  agent packet; channel i uses slice i.
- full  out  drvrs  TX FIFO i holds `depth` entries.
- count  out  drvrs*$clog2(depth+1)  occupancy per channel.
- pndng  out  drvrs  to arbiter: TX FIFO i is non-empty.
- D_pop  out  drvrs*pckg_sz  to arbiter: head of TX FIFO i.
- pop  in  drvrs  from arbiter: consume head of FIFO i.
- push  in  drvrs  from arbiter: deliver packet to channel i.
- D_push  in  drvrs*pckg_sz  from arbiter: delivered packet.
- rx_data  out  drvrs*pckg_sz  captured packet per channel.
- rx_vld  out  drvrs  capture valid.
- rx_bcst  out  drvrs  captured packet id == `broadcast`.
- rx_ack  in  drvrs  agent consumes capture.
- rx_ovr  out  drvrs  sticky: capture overwritten while unread.
- pop_err  out  drvrs  sticky: pop while empty.
- drop_cnt  out  drvrs*8  per-channel overflow event counter, saturating at 255.

Behaviour:
- **Reset.** Asserting `reset` asynchronously clears all pointers and counts and all of: `pndng`, `full`, `count`, `rx_vld`, `rx_bcst`, `rx_ovr`, `pop_err`, `drop_cnt`. `rx_data` and `D_pop` are driven to 0. Reset mid-operation discards all FIFO contents. Normal operation resumes on the first rising edge after deassertion.
- **TX FIFO, first-word-fall-through.**
  - `D_pop[i]` is the head entry, read from registered storage with no extra cycle.
  - `pndng[i] = (count[i] != 0)`.
  - Write-to-`pndng` latency: 1 cycle. A write at edge N gives `pndng = 1` and valid `D_pop` after edge N.
  - Pop latency: the head advances at the edge where `pop[i] = 1`. The next entry appears on `D_pop` after that edge.
- **Write, not full:** entry stored at the tail; count +1.
- **Pop, not empty:** head advances; count −1.
- **Write + pop in the same cycle, not empty and not full:** both performed; count unchanged.
- **Write + pop in the same cycle, full:** both performed; count stays at `depth`; no drop counted.
- **Write + pop in the same cycle, empty:** pop ignored and `pop_err` set; write accepted; count becomes 1.
- **Write when full, no pop:**
  - `ovf_mode = 0`: packet discarded; FIFO unchanged.
  - `ovf_mode = 1`: head advances and the new packet is written at the tail; count stays at `depth`.
  - Both modes: `drop_cnt[i]` +1, saturating at 255.
- **Pop when empty:** no state change except `pop_err[i]` is set (sticky until reset).
- **Pointer arithmetic:** pointers are `$clog2(depth)` bits and wrap modulo `depth`; `count` is one bit wider.
- **RX capture, on `push[i]`:**
  - `rx_data[i]` is loaded from `D_push[i]` and `rx_vld[i]` is set.
  - `rx_bcst[i]` is set to (id field == `broadcast`).
- **`rx_ack[i]` with `rx_vld[i]` set** clears `rx_vld[i]`. `rx_ack` while not valid is ignored.
- **`push` and `rx_ack` in the same cycle:** the new packet is captured and `rx_vld` stays 1; not an overrun.
- **`push` while `rx_vld = 1` and no `rx_ack`:** capture is overwritten and `rx_ovr[i]` is set (sticky).
- **Channel independence:** all channels are fully independent, with no shared state.

Test Plan:
- **Reset then single write.** Reset, then `wr_en[0]` with 16'hFF33 for 1 cycle → next cycle `pndng[0] = 1`, `D_pop[0] = FF33`, `count[0] = 1`. Then `pop[0]` → `pndng[0] = 0`, `count[0] = 0`.
- **Fill, ordering and drop mode.** `ovf_mode = 0`, `depth = 8`: write 0x0100..0x0108 (9 packets) to ch2 → `full[2] = 1`, `drop_cnt[2] = 1`. 8 pops return 0x0100..0x0107 in order; 0x0108 is lost.
- **Overwrite mode.** Same stimulus with `ovf_mode = 1` → pops return 0x0101..0x0108 and `drop_cnt[2] = 1`. Then 300 further overflow writes → `drop_cnt` holds 255.
- **Simultaneous events.**
  - Full ch1, write + pop in the same cycle → `count` stays 8, `drop_cnt[1] = 0`, new tail present.
  - Empty ch3, pop + write → `pop_err[3] = 1`, `count[3] = 1`.
- **RX path.**
  - `push[1]` with 0xFF55 → `rx_vld[1] = 1`, `rx_bcst[1] = 1`.
  - Second `push[1]` with 0x0277 and no ack → `rx_data[1] = 0277`, `rx_bcst[1] = 0`, `rx_ovr[1] = 1`.
  - `push` + `rx_ack` in the same cycle → no overrun.
- **Reset mid-operation.** With 5 entries in ch0 and `rx_vld[0] = 1`, assert `reset` between clock edges → all outputs clear immediately (asynchronously). After release, a write shows `D_pop` = the new data only.
